sc_ulpi_upp: RTL

ULPI Packet Parser, the receive-side counterpart of the ULPI packet generator. It sits between the ULPI protocol engine RX byte stream and the USB transaction layer. It validates the PID, decodes token, SOF, handshake and data packets, and checks CRC5 and CRC16. Payload bytes are forwarded with the CRC bytes stripped, and one completion strobe carrying status is issued per packet.

---
 rtl/sc_ulpi_upp.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sc_ulpi_upp.sv
// Receive-side ULPI packet parser: validates PIDs, decodes token/SOF/handshake/data
// packets, checks CRC5/CRC16, strips CRC bytes from payload and strobes a completion.
module sc_ulpi_upp #(
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic        ULPICLK,
    input  logic        ULPIRST,
    input  logic        RXD_VALID,
    input  logic [7:0]  RXD_DATA,
    input  logic        RXD_END,
    input  logic        RXD_ERR,
    output logic        PKT_RX_COMP,
    output logic [3:0]  PKT_RX_PID,
    output logic [6:0]  PKT_RX_ADR,
    output logic [3:0]  PKT_RX_EPN,
    output logic [10:0] PKT_RX_FMN,
    output logic [10:0] PKT_RX_NUM,
    output logic [3:0]  PKT_RX_ERR,
    output logic [7:0]  PKT_RX_DAT,
    output logic        PKT_RX_DAT_VALID
);

    typedef enum logic [2:0] {RxIdle, RxTok1, RxTok2, RxChk, RxHs, RxData, RxDrop} state_e;

    localparam logic [10:0] MaxNum  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] OverNum = 11'(MAX_PAYLOAD + 1);

    state_e      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  adr_q, adr_d;
    logic [3:0]  epn_q, epn_d;
    logic [10:0] fmn_q, fmn_d;
    logic [10:0] num_q, num_d;
    logic [3:0]  err_q, err_d;
    logic [7:0]  dat_q, dat_d;
    logic        dat_vld_q, dat_vld_d;
    logic        comp_q, comp_d;
    logic [7:0]  tok_lo_q, tok_lo_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [7:0]  hold0_q, hold0_d;
    logic [7:0]  hold1_q, hold1_d;
    logic [1:0]  held_q, held_d;
    logic [10:0] field;

    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[4] ^ b[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign field = {RXD_DATA[2:0], tok_lo_q};

    always_comb begin
        state_d   = state_q;
        pid_d     = pid_q;
        adr_d     = adr_q;
        epn_d     = epn_q;
        fmn_d     = fmn_q;
        num_d     = num_q;
        err_d     = err_q;
        dat_d     = dat_q;
        dat_vld_d = 1'b0;
        comp_d    = 1'b0;
        tok_lo_d  = tok_lo_q;
        crc5_d    = crc5_q;
        crc16_d   = crc16_q;
        hold0_d   = hold0_q;
        hold1_d   = hold1_q;
        held_d    = held_q;
        if (state_q == RxIdle) begin
            if (RXD_VALID) begin
                err_d   = '0;
                num_d   = '0;
                held_d  = '0;
                crc5_d  = 5'h1f;
                crc16_d = 16'hffff;
                if (RXD_DATA[7:4] != ~RXD_DATA[3:0]) begin
                    err_d[0] = 1'b1;
                    state_d  = RxDrop;
                end else begin
                    pid_d = RXD_DATA[3:0];
                    unique case (RXD_DATA[3:0])
                        4'h1, 4'h9, 4'hD, 4'h4, 4'h5: state_d = RxTok1;
                        4'h3, 4'hB, 4'h7, 4'hF:       state_d = RxData;
                        4'h2, 4'hA, 4'hE, 4'h6:       state_d = RxHs;
                        default: begin
                            err_d[2] = 1'b1;
                            state_d  = RxDrop;
                        end
                    endcase
                end
            end
        end else if (RXD_END) begin
            comp_d  = 1'b1;
            state_d = RxIdle;
            case (state_q)
                RxTok1, RxTok2: err_d[2] = 1'b1;
                RxChk: if (crc5_q != 5'b01100) err_d[1] = 1'b1;
                // CRC16 is only meaningful once both CRC bytes were received
                RxData: begin
                    if (held_q != 2'd2)           err_d[2] = 1'b1;
                    else if (crc16_q != 16'h800D) err_d[1] = 1'b1;
                end
                default: ;
            endcase
            if (RXD_ERR) err_d[3] = 1'b1;
        end else if (RXD_ERR) begin
            err_d[3] = 1'b1;
            state_d  = RxDrop;
        end else if (RXD_VALID) begin
            case (state_q)
                RxTok1: begin
                    tok_lo_d = RXD_DATA;
                    crc5_d   = crc5_byte(crc5_q, RXD_DATA);
                    state_d  = RxTok2;
                end
                RxTok2: begin
                    crc5_d = crc5_byte(crc5_q, RXD_DATA);
                    if (pid_q == 4'h5) begin
                        fmn_d = field;
                    end else begin
                        adr_d = field[6:0];
                        epn_d = field[10:7];
                    end
                    state_d = RxChk;
                end
                RxChk, RxHs: begin
                    err_d[2] = 1'b1;
                    state_d  = RxDrop;
                end
                RxData: begin
                    crc16_d = crc16_byte(crc16_q, RXD_DATA);
                    // The two most recent bytes may be the CRC, so only older bytes leave
                    if (held_q == 2'd2) begin
                        if (num_q < MaxNum) begin
                            dat_d     = hold1_q;
                            dat_vld_d = 1'b1;
                            num_d     = num_q + 11'd1;
                        end else if (num_q == MaxNum) begin
                            num_d    = OverNum;
                            err_d[2] = 1'b1;
                        end
                    end else begin
                        held_d = held_q + 2'd1;
                    end
                    hold1_d = hold0_q;
                    hold0_d = RXD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ULPICLK) begin
        if (ULPIRST) begin
            state_q   <= RxIdle;
            pid_q     <= '0;
            adr_q     <= '0;
            epn_q     <= '0;
            fmn_q     <= '0;
            num_q     <= '0;
            err_q     <= '0;
            dat_q     <= '0;
            dat_vld_q <= 1'b0;
            comp_q    <= 1'b0;
            tok_lo_q  <= '0;
            crc5_q    <= 5'h1f;
            crc16_q   <= 16'hffff;
            hold0_q   <= '0;
            hold1_q   <= '0;
            held_q    <= '0;
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            adr_q     <= adr_d;
            epn_q     <= epn_d;
            fmn_q     <= fmn_d;
            num_q     <= num_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            dat_vld_q <= dat_vld_d;
            comp_q    <= comp_d;
            tok_lo_q  <= tok_lo_d;
            crc5_q    <= crc5_d;
            crc16_q   <= crc16_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
            held_q    <= held_d;
        end
    end

    assign PKT_RX_COMP      = comp_q;
    assign PKT_RX_PID       = pid_q;
    assign PKT_RX_ADR       = adr_q;
    assign PKT_RX_EPN       = epn_q;
    assign PKT_RX_FMN       = fmn_q;
    assign PKT_RX_NUM       = num_q;
    assign PKT_RX_ERR       = err_q;
    assign PKT_RX_DAT       = dat_q;
    assign PKT_RX_DAT_VALID = dat_vld_q;

endmodule
